// File: rtl/traffic_light_controller.sv
// Two-way intersection controller with latched vehicle/pedestrian demand and a walk phase.
// Lamps, walk and state_out are registered from the next-state decode, so they always track the state register.
module traffic_light_controller #(
   parameter int unsigned GREEN_TIME  = 8,
   parameter int unsigned YELLOW_TIME = 3,
   parameter int unsigned ALLRED_TIME = 1,
   parameter int unsigned WALK_TIME   = 5,
   parameter int unsigned CNT_WIDTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] state_out
);

   if (GREEN_TIME < 1 || YELLOW_TIME < 1 || ALLRED_TIME < 1 || WALK_TIME < 1 ||
       ((GREEN_TIME - 1) >> CNT_WIDTH) != 0 || ((YELLOW_TIME - 1) >> CNT_WIDTH) != 0 ||
       ((ALLRED_TIME - 1) >> CNT_WIDTH) != 0 || ((WALK_TIME - 1) >> CNT_WIDTH) != 0) begin : g_param_check
      $error("traffic_light_controller: phase times must be >=1 and TIME-1 must fit in CNT_WIDTH");
   end

   localparam logic [CNT_WIDTH-1:0] T_GREEN  = CNT_WIDTH'(GREEN_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] T_YELLOW = CNT_WIDTH'(YELLOW_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] T_ALLRED = CNT_WIDTH'(ALLRED_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] T_WALK   = CNT_WIDTH'(WALK_TIME - 1);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      RED_A     = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      RED_B     = 3'd5,
      WALK      = 3'd6
   } state_t;

   state_t                 state;
   state_t                 nxt;
   logic [CNT_WIDTH-1:0]   timer;
   logic [CNT_WIDTH-1:0]   load_val;
   logic                   ns_pend;
   logic                   ew_pend;
   logic                   ped_pend;
   logic                   next_dir;
   logic                   tdone;
   logic                   ped_any;
   logic                   entering;
   logic [2:0]             nxt_ns;
   logic [2:0]             nxt_ew;
   logic                   nxt_walk;

   always_comb begin
      nxt      = state;
      tdone    = (timer == '0);
      ped_any  = ped_pend | ped_req;
      case (state)
         NS_GREEN:  if (tdone && (ew_pend || car_ew || ped_any)) nxt = NS_YELLOW;
         NS_YELLOW: if (tdone) nxt = RED_A;
         RED_A:     if (tdone) nxt = ped_any ? WALK : EW_GREEN;
         EW_GREEN:  if (tdone && (ns_pend || car_ns || ped_any)) nxt = EW_YELLOW;
         EW_YELLOW: if (tdone) nxt = RED_B;
         RED_B:     if (tdone) nxt = ped_any ? WALK : NS_GREEN;
         WALK:      if (tdone) nxt = next_dir ? EW_GREEN : NS_GREEN;
         default:   nxt = RED_B;
      endcase
      entering = (nxt != state);

      load_val = T_ALLRED;
      case (nxt)
         NS_GREEN, EW_GREEN:   load_val = T_GREEN;
         NS_YELLOW, EW_YELLOW: load_val = T_YELLOW;
         WALK:                 load_val = T_WALK;
         default:              load_val = T_ALLRED;
      endcase

      nxt_ns   = 3'b100;
      nxt_ew   = 3'b100;
      nxt_walk = 1'b0;
      case (nxt)
         NS_GREEN:  nxt_ns = 3'b001;
         NS_YELLOW: nxt_ns = 3'b010;
         EW_GREEN:  nxt_ew = 3'b001;
         EW_YELLOW: nxt_ew = 3'b010;
         WALK:      nxt_walk = 1'b1;
         default:   nxt_walk = 1'b0;
      endcase
   end

   // Demand that arrives on the same edge its phase is entered is dropped: that phase serves it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RED_B;
         timer     <= T_ALLRED;
         ns_pend   <= 1'b0;
         ew_pend   <= 1'b0;
         ped_pend  <= 1'b0;
         next_dir  <= 1'b0;
         ns_light  <= 3'b100;
         ew_light  <= 3'b100;
         walk      <= 1'b0;
         state_out <= 3'd5;
      end else begin
         state <= nxt;
         if (entering)
            timer <= load_val;
         else if (timer != '0)
            timer <= timer - CNT_WIDTH'(1);

         ew_pend  <= (entering && nxt == EW_GREEN) ? 1'b0 : (ew_pend | (car_ew & (state != EW_GREEN)));
         ns_pend  <= (entering && nxt == NS_GREEN) ? 1'b0 : (ns_pend | (car_ns & (state != NS_GREEN)));
         ped_pend <= (entering && nxt == WALK) ? 1'b0 : (ped_pend | ped_req);
         if (entering && nxt == WALK)
            next_dir <= (state == RED_A);

         ns_light  <= nxt_ns;
         ew_light  <= nxt_ew;
         walk      <= nxt_walk;
         state_out <= nxt;
      end
   end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: directed phase-timing scenarios plus randomized
// traffic compared against a phase-age reference model.
module tb_traffic_light_controller;

   localparam int G  = 8;
   localparam int Y  = 3;
   localparam int AR = 1;
   localparam int W  = 5;
   localparam int PEND_BOUND = 2 * (G + Y + AR) + W;

   logic       clk;
   logic       rst_n;
   logic       car_ns;
   logic       car_ew;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic [2:0] state_out;

   int n_checks;
   int n_fail;

   // Reference model: state code, cycles spent in the current phase, demand flags.
   int m_st;
   int m_age;
   bit m_ns, m_ew, m_ped, m_dir;

   traffic_light_controller #(
      .GREEN_TIME (G),
      .YELLOW_TIME(Y),
      .ALLRED_TIME(AR),
      .WALK_TIME  (W),
      .CNT_WIDTH  (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .car_ns   (car_ns),
      .car_ew   (car_ew),
      .ped_req  (ped_req),
      .ns_light (ns_light),
      .ew_light (ew_light),
      .walk     (walk),
      .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dur(input int s);
      case (s)
         0, 3:    return G;
         1, 4:    return Y;
         2, 5:    return AR;
         default: return W;
      endcase
   endfunction

   function automatic logic [2:0] ns_of(input int s);
      return (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
   endfunction

   function automatic logic [2:0] ew_of(input int s);
      return (s == 3) ? 3'b001 : (s == 4) ? 3'b010 : 3'b100;
   endfunction

   task automatic model_step(input logic r, input logic cn, input logic ce, input logic pr);
      int nst;
      bit done, pa;
      if (!r) begin
         m_st = 5; m_age = 0; m_ns = 0; m_ew = 0; m_ped = 0;
      end else begin
         done = (m_age >= dur(m_st) - 1);
         pa   = m_ped | pr;
         nst  = m_st;
         case (m_st)
            0: if (done && (m_ew || ce || pa)) nst = 1;
            1: if (done) nst = 2;
            2: if (done) nst = pa ? 6 : 3;
            3: if (done && (m_ns || cn || pa)) nst = 4;
            4: if (done) nst = 5;
            5: if (done) nst = pa ? 6 : 0;
            default: if (done) nst = m_dir ? 3 : 0;
         endcase
         if (nst == 6 && m_st != 6) m_dir = (m_st == 2);
         m_ew  = (nst == 3 && m_st != 3) ? 1'b0 : (m_ew | (ce && m_st != 3));
         m_ns  = (nst == 0 && m_st != 0) ? 1'b0 : (m_ns | (cn && m_st != 0));
         m_ped = (nst == 6 && m_st != 6) ? 1'b0 : (m_ped | pr);
         m_age = (nst != m_st) ? 0 : ((m_age < 100000) ? m_age + 1 : m_age);
         m_st  = nst;
      end
   endtask

   task automatic tick(input logic r, input logic cn, input logic ce, input logic pr);
      rst_n = r; car_ns = cn; car_ew = ce; ped_req = pr;
      @(posedge clk);
      model_step(r, cn, ce, pr);
      #1;
   endtask

   task automatic test_reset();
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      n_checks++;
      if (state_out !== 3'd5) begin n_fail++; $display("FAIL reset_state got %0d want 5", state_out); end
      n_checks++;
      if (ns_light !== 3'b100 || ew_light !== 3'b100 || walk !== 1'b0) begin
         n_fail++; $display("FAIL reset_lights got ns=%b ew=%b walk=%b want 100 100 0", ns_light, ew_light, walk);
      end
      n_checks++;
      if ({dut.ns_pend, dut.ew_pend, dut.ped_pend} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pend got %b want 000", {dut.ns_pend, dut.ew_pend, dut.ped_pend});
      end
      for (int k = 0; k < 20; k++) begin
         tick(1, 0, 0, 0);
         n_checks++;
         if (state_out !== 3'd0 || ns_light !== 3'b001 || ew_light !== 3'b100) begin
            n_fail++; $display("FAIL reset_idle_ns_hold cyc %0d got st=%0d ns=%b ew=%b want 0 001 100", k, state_out, ns_light, ew_light);
         end
      end
   endtask

   task automatic test_ew_demand();
      logic [2:0] exp;
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         if (k < G) exp = 3'd0;
         else if (k < G + Y) exp = 3'd1;
         else if (k < G + Y + AR) exp = 3'd2;
         else exp = 3'd3;
         n_checks++;
         if (state_out !== exp) begin n_fail++; $display("FAIL ew_demand_seq k=%0d got %0d want %0d", k, state_out, exp); end
         if (k == 5) begin
            n_checks++;
            if (dut.ew_pend !== 1'b1) begin n_fail++; $display("FAIL ew_pend_set got %b want 1", dut.ew_pend); end
         end
         if (k == G + Y + AR) begin
            n_checks++;
            if (dut.ew_pend !== 1'b0) begin n_fail++; $display("FAIL ew_pend_clear got %b want 0", dut.ew_pend); end
         end
         tick(1, 0, (k == 1), 0);
      end
   endtask

   task automatic test_ped_walk();
      logic [2:0] exp;
      for (int k = 0; k < 5; k++) begin
         tick(1, 0, 0, 0);
         n_checks++;
         if (state_out !== 3'd3) begin n_fail++; $display("FAIL ped_pre_ew_hold got %0d want 3", state_out); end
      end
      for (int j = 0; j < 12; j++) begin
         tick(1, 1, 0, (j == 0));
         if (j < Y) exp = 3'd4;
         else if (j < Y + AR) exp = 3'd5;
         else if (j < Y + AR + W) exp = 3'd6;
         else exp = 3'd0;
         n_checks++;
         if (state_out !== exp) begin n_fail++; $display("FAIL ped_walk_seq j=%0d got %0d want %0d", j, state_out, exp); end
         n_checks++;
         if (walk !== (exp == 3'd6) || ns_light !== ns_of(int'(exp)) || ew_light !== ew_of(int'(exp))) begin
            n_fail++; $display("FAIL ped_walk_out j=%0d got walk=%b ns=%b ew=%b want walk=%b ns=%b ew=%b",
                               j, walk, ns_light, ew_light, (exp == 3'd6), ns_of(int'(exp)), ew_of(int'(exp)));
         end
         if (j >= Y + AR + W) begin
            n_checks++;
            if (dut.ns_pend !== 1'b0) begin n_fail++; $display("FAIL ns_pend_after_ns_entry got %b want 0", dut.ns_pend); end
         end
      end
   endtask

   task automatic test_ew_hold();
      logic [2:0] exp;
      tick(0, 0, 0, 0);
      tick(1, 0, 1, 0);
      for (int k = 0; k < 40; k++) begin
         if (k < G) exp = 3'd0;
         else if (k < G + Y) exp = 3'd1;
         else if (k < G + Y + AR) exp = 3'd2;
         else exp = 3'd3;
         n_checks++;
         if (state_out !== exp) begin n_fail++; $display("FAIL ew_hold_seq k=%0d got %0d want %0d", k, state_out, exp); end
         if (k >= G + Y + AR) begin
            n_checks++;
            if (dut.ew_pend !== 1'b0) begin n_fail++; $display("FAIL ew_pend_in_ew_green k=%0d got %b want 0", k, dut.ew_pend); end
         end
         tick(1, 0, 1, 0);
      end
   endtask

   task automatic test_mid_reset();
      bit seen;
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 1);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (state_out === 3'd1) seen = 1;
         else tick(1, 0, 0, 0);
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL mid_reset_reach_yellow got %0d want 1", state_out); end
      n_checks++;
      if (dut.ped_pend !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ped_pend got %b want 1", dut.ped_pend); end
      tick(0, 0, 0, 0);
      n_checks++;
      if (state_out !== 3'd5 || ns_light !== 3'b100 || ew_light !== 3'b100 || walk !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_out got st=%0d ns=%b ew=%b walk=%b want 5 100 100 0", state_out, ns_light, ew_light, walk);
      end
      n_checks++;
      if ({dut.ns_pend, dut.ew_pend, dut.ped_pend} !== 3'b000) begin
         n_fail++; $display("FAIL mid_reset_pend got %b want 000", {dut.ns_pend, dut.ew_pend, dut.ped_pend});
      end
      for (int k = 0; k < 15; k++) begin
         tick(1, 0, 0, 0);
         n_checks++;
         if (state_out !== 3'd0 || walk !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_walk k=%0d got st=%0d walk=%b want 0 0", k, state_out, walk);
         end
      end
   endtask

   task automatic test_random();
      logic r, cn, ce, pr;
      int a_ns, a_ew, a_ped;
      a_ns = 0; a_ew = 0; a_ped = 0;
      tick(0, 0, 0, 0);
      for (int i = 0; i < 10000; i++) begin
         r  = ($urandom_range(0, 1999) != 0);
         cn = ($urandom_range(0, 3) == 0);
         ce = ($urandom_range(0, 3) == 0);
         pr = ($urandom_range(0, 15) == 0);
         tick(r, cn, ce, pr);
         n_checks++;
         if (state_out !== 3'(m_st)) begin n_fail++; $display("FAIL rand_state i=%0d got %0d want %0d", i, state_out, m_st); end
         n_checks++;
         if (ns_light !== ns_of(m_st) || ew_light !== ew_of(m_st) || walk !== (m_st == 6)) begin
            n_fail++; $display("FAIL rand_outputs i=%0d got ns=%b ew=%b walk=%b want %b %b %b",
                               i, ns_light, ew_light, walk, ns_of(m_st), ew_of(m_st), (m_st == 6));
         end
         n_checks++;
         if ({dut.ns_pend, dut.ew_pend, dut.ped_pend} !== {m_ns, m_ew, m_ped}) begin
            n_fail++; $display("FAIL rand_pend i=%0d got %b want %b", i, {dut.ns_pend, dut.ew_pend, dut.ped_pend}, {m_ns, m_ew, m_ped});
         end
         n_checks++;
         if ($countones(ns_light) != 1 || $countones(ew_light) != 1) begin
            n_fail++; $display("FAIL rand_onehot i=%0d got ns=%b ew=%b want one-hot", i, ns_light, ew_light);
         end
         n_checks++;
         if ((ns_light !== 3'b100 && ew_light !== 3'b100) || (walk && (ns_light !== 3'b100 || ew_light !== 3'b100))) begin
            n_fail++; $display("FAIL rand_invariant i=%0d got ns=%b ew=%b walk=%b want conflict-free", i, ns_light, ew_light, walk);
         end
         a_ns  = dut.ns_pend  ? a_ns + 1  : 0;
         a_ew  = dut.ew_pend  ? a_ew + 1  : 0;
         a_ped = dut.ped_pend ? a_ped + 1 : 0;
         n_checks++;
         if (a_ns > PEND_BOUND || a_ew > PEND_BOUND || a_ped > PEND_BOUND) begin
            n_fail++; $display("FAIL rand_pend_age i=%0d got ns=%0d ew=%0d ped=%0d want <= %0d", i, a_ns, a_ew, a_ped, PEND_BOUND);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_st = 5; m_age = 0; m_ns = 0; m_ew = 0; m_ped = 0; m_dir = 0;
      rst_n = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0;
      test_reset();
      test_ew_demand();
      test_ped_walk();
      test_ew_hold();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
- Two-way intersection controller (north-south / east-west) with a pedestrian walk phase.
- Produces the light and walk indications from a registered state and a phase down-counter.
- Acts as the driving side of the codebase's registered-state path: it computes and holds the state that the light outputs read.
- Vehicle and pedestrian requests are latched as pending demand. Each green phase has a guaranteed minimum duration and is extended indefinitely while no other demand exists.

Parameters:
- GREEN_TIME, 8, minimum green duration in cycles (>=1).
- YELLOW_TIME, 3, yellow duration in cycles (>=1).
- ALLRED_TIME, 1, all-red clearance duration in cycles (>=1).
- WALK_TIME, 5, walk phase duration in cycles (>=1).
- CNT_WIDTH, 4, phase timer width. Every *_TIME-1 must fit in this width; a violation is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- car_ns  input  1  vehicle present on NS approach, sampled each edge
- car_ew  input  1  vehicle present on EW approach, sampled each edge
- ped_req  input  1  pedestrian button, level or pulse, sampled each edge
- ns_light  output  3  NS lamps {red,yellow,green}, exactly one bit set
- ew_light  output  3  EW lamps {red,yellow,green}, exactly one bit set
- walk  output  1  walk indication
- state_out  output  3  current state encoding, for debug/monitoring

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low: sampled only on the rising edge of clk; any edge with rst_n=0 applies reset.
- State encoding (state_out): 0 NS_GREEN, 1 NS_YELLOW, 2 RED_A, 3 EW_GREEN, 4 EW_YELLOW, 5 RED_B, 6 WALK. Code 7 is illegal and recovers to RED_B on the next edge.
- Reset values:
  - state = RED_B, timer = ALLRED_TIME-1.
  - ns_pend, ew_pend, ped_pend = 0.
  - ns_light = ew_light = 3'b100; walk = 0; state_out = 5.
- Outputs are decoded from the state register only; there is no combinational path from inputs to outputs.
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - RED_A / RED_B: both 100, walk=0.
  - WALK: both 100, walk=1.
- Timer:
  - Loaded with <PHASE>_TIME-1 on every state entry.
  - Decrements by 1 each cycle while nonzero.
  - Holds at 0; never wraps.
  - Each timed phase therefore lasts exactly <PHASE>_TIME cycles when exited at the first opportunity.
- Demand latches:
  - ew_pend is set when car_ew=1 in any state except EW_GREEN, and cleared on the edge entering EW_GREEN.
  - ns_pend is the mirror of ew_pend (car_ns, NS_GREEN).
  - ped_pend is set on ped_req=1 and cleared on the edge entering WALK.
  - Set and clear on the same edge: clear wins, because the request is being served.
- Transitions (all evaluated at the rising edge):
  - NS_GREEN: if timer==0 and (ew_pend|car_ew|ped_pend|ped_req) go to NS_YELLOW; otherwise hold with timer at 0.
  - NS_YELLOW: timer==0 goes to RED_A.
  - RED_A: timer==0 goes to WALK if (ped_pend|ped_req), else to EW_GREEN.
  - EW_GREEN: if timer==0 and (ns_pend|car_ns|ped_pend|ped_req) go to EW_YELLOW; otherwise hold.
  - EW_YELLOW: timer==0 goes to RED_B.
  - RED_B: timer==0 goes to WALK if (ped_pend|ped_req), else to NS_GREEN.
  - WALK: timer==0 goes to EW_GREEN if entered from RED_A, or to NS_GREEN if entered from RED_B. A 1-bit next_dir register, captured on WALK entry, records the origin.
- Green hold: with no demand, the green phase holds indefinitely. Once the minimum time has expired, demand that arrives while holding moves the state to YELLOW on the same edge it is sampled, visible the following cycle.
- Mid-operation reset: the next edge with rst_n=0 forces the reset values regardless of state or timer; pending demand is discarded.
- Invariant: ns_light and ew_light are never both non-red, and walk=1 only when both are red.

Test Plan:
- Reset with defaults, no inputs: rst_n low for 2 edges, then high.
  -> state_out=5 for 1 cycle, then 0 (NS green), held indefinitely with timer at 0.
- car_ew pulsed 1 cycle at cycle 2 of NS_GREEN.
  -> NS_GREEN lasts exactly 8 cycles, NS_YELLOW 3, RED_A 1, then EW_GREEN.
  -> ew_pend is 0 after EW_GREEN entry.
- ped_req pulse during EW_GREEN with car_ns steady high.
  -> EW_YELLOW(3), RED_B(1), WALK(5) with walk=1 and both lights 100, then NS_GREEN.
- car_ew held high throughout NS_GREEN, car_ns idle.
  -> leaves NS_GREEN after exactly 8 cycles.
  -> EW_GREEN then holds forever; ew_pend never set while in EW_GREEN.
- rst_n asserted low for 1 edge during NS_YELLOW with ped_pend=1.
  -> next cycle state_out=5, all pends 0, both lights 100.
  -> returns to NS_GREEN without entering WALK.
- Random car_ns, car_ew and ped_req for 10k cycles.
  -> invariant never violated, lights always one-hot.
  -> every set pend is cleared within 2*(GREEN_TIME+YELLOW_TIME+ALLRED_TIME)+WALK_TIME cycles.
